// File: rtl/axil_slave_regfile_pkg.sv
// Shared AXI4-Lite response encodings and address helpers for the subsystem register file.
package subsystem_axil_pkg;

  typedef logic [1:0] axil_resp_t;

  localparam axil_resp_t AXI_RESP_OKAY   = 2'b00;
  localparam axil_resp_t AXI_RESP_EXOKAY = 2'b01;
  localparam axil_resp_t AXI_RESP_SLVERR = 2'b10;
  localparam axil_resp_t AXI_RESP_DECERR = 2'b11;

  localparam int unsigned AXIL_DATA_W = 32;

  // Byte address width minus the two byte-lane bits gives the word index width.
  function automatic int unsigned axil_idx_w(input int unsigned addr_w);
    return addr_w - 2;
  endfunction

endpackage

// File: rtl/axil_slave_regfile_if.sv
// AXI4-Lite bus bundle with master/slave modports.
interface axil_slave_regfile_if
  import subsystem_axil_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = AXIL_DATA_W
) ();

  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] AWADDR;
  logic [2:0]        AWPROT;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              WVALID;
  logic              WREADY;
  axil_resp_t        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [2:0]        ARPROT;
  logic              ARVALID;
  logic              ARREADY;
  logic [DATA_W-1:0] RDATA;
  axil_resp_t        RRESP;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input BRESP, BVALID, output BREADY,
    output ARADDR, ARPROT, ARVALID, input ARREADY,
    input RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input AWADDR, AWPROT, AWVALID, output AWREADY,
    input WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );

endinterface

// File: rtl/axil_slave_regfile_reg_bank.sv
// Register array: byte-strobed synchronous write, combinational indexed read, flattened contents out.
module axil_reg_bank #(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned IDX_W    = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_we,
  input  logic [IDX_W-1:0]       i_widx,
  input  logic [31:0]            i_wdata,
  input  logic [3:0]             i_wstrb,
  input  logic [IDX_W-1:0]       i_ridx,
  output logic [31:0]            o_rdata_c,
  output logic [NUM_REGS*32-1:0] o_reg_q
);

  logic [31:0] r_regs [NUM_REGS];

  // Indices with no matching register simply never match, which drops the write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) r_regs[i] <= '0;
    end else if (i_we) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        for (int b = 0; b < 4; b++) begin
          if (i_widx == IDX_W'(i) && i_wstrb[b]) r_regs[i][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    o_rdata_c = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (i_ridx == IDX_W'(i)) o_rdata_c = r_regs[i];
    end
  end

  always_comb begin
    o_reg_q = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) o_reg_q[32*i +: 32] = r_regs[i];
  end

endmodule

// File: rtl/axil_slave_regfile.sv
// AXI4-Lite responder over a bank of NUM_REGS 32-bit registers.
// Define SUBSYS_AXIL_DECERR_RESP_EN to answer out-of-range indices with SLVERR instead of OKAY.
module axil_slave_regfile
  import subsystem_axil_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
  parameter int unsigned NUM_REGS           = 4
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  axil_slave_regfile_if.slave    S_AXI,
  output logic [NUM_REGS*32-1:0] reg_q
);

  localparam int unsigned IDX_W = axil_idx_w(C_S_AXI_ADDR_WIDTH);

  if (C_S_AXI_DATA_WIDTH != AXIL_DATA_W) begin : g_bad_width
    $error("axil_slave_regfile supports only 32-bit data");
  end
  if (NUM_REGS < 1 || NUM_REGS > (1 << IDX_W)) begin : g_bad_regs
    $error("axil_slave_regfile NUM_REGS out of range");
  end

  logic             r_aw_held;
  logic [IDX_W-1:0] r_aw_idx;
  logic             r_w_held;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wstrb;
  logic             r_bvalid;
  axil_resp_t       r_bresp;
  logic             r_rvalid;
  logic [31:0]      r_rdata;
  axil_resp_t       r_rresp;

  logic             w_awready, w_wready, w_arready;
  logic             w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [IDX_W-1:0] w_aw_idx, w_ar_idx, w_wr_idx;
  logic [31:0]      w_wr_data, w_rd_data_c;
  logic [3:0]       w_wr_strb;
  axil_resp_t       w_wr_resp, w_rd_resp;
  logic             w_unused;

  // READYs depend only on registered state, never on the incoming VALIDs.
  assign w_awready = !r_aw_held && !r_bvalid;
  assign w_wready  = !r_w_held && !r_bvalid;
  assign w_arready = !r_rvalid;

  assign w_aw_hs  = S_AXI.AWVALID && w_awready;
  assign w_w_hs   = S_AXI.WVALID && w_wready;
  assign w_ar_hs  = S_AXI.ARVALID && w_arready;
  assign w_commit = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

  assign w_aw_idx  = S_AXI.AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_ar_idx  = S_AXI.ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_wr_idx  = r_aw_held ? r_aw_idx : w_aw_idx;
  assign w_wr_data = r_w_held ? r_wdata : S_AXI.WDATA;
  assign w_wr_strb = r_w_held ? r_wstrb : S_AXI.WSTRB;

`ifdef SUBSYS_AXIL_DECERR_RESP_EN
  assign w_wr_resp = (32'(w_wr_idx) >= NUM_REGS) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign w_rd_resp = (32'(w_ar_idx) >= NUM_REGS) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
`else
  assign w_wr_resp = AXI_RESP_OKAY;
  assign w_rd_resp = AXI_RESP_OKAY;
`endif

  assign w_unused = ^{S_AXI.AWPROT, S_AXI.ARPROT, S_AXI.AWADDR[1:0], S_AXI.ARADDR[1:0]};

  axil_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_bank (
    .i_clk     (ACLK),
    .i_rst     (ARESET),
    .i_we      (w_commit),
    .i_widx    (w_wr_idx),
    .i_wdata   (w_wr_data),
    .i_wstrb   (w_wr_strb),
    .i_ridx    (w_ar_idx),
    .o_rdata_c (w_rd_data_c),
    .o_reg_q   (reg_q)
  );

  // Write path: AW and W park independently; commit once both are present.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_aw_held <= 1'b0;
      r_aw_idx  <= '0;
      r_w_held  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= AXI_RESP_OKAY;
    end else if (w_commit) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b1;
      r_bresp   <= w_wr_resp;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_idx  <= w_aw_idx;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= S_AXI.WDATA;
        r_wstrb  <= S_AXI.WSTRB;
      end
      if (r_bvalid && S_AXI.BREADY) r_bvalid <= 1'b0;
    end
  end

  // Read path samples the bank before any same-edge write lands.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= AXI_RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data_c;
      r_rresp  <= w_rd_resp;
    end else if (r_rvalid && S_AXI.RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  assign S_AXI.AWREADY = w_awready;
  assign S_AXI.WREADY  = w_wready;
  assign S_AXI.ARREADY = w_arready;
  assign S_AXI.BVALID  = r_bvalid;
  assign S_AXI.BRESP   = r_bresp;
  assign S_AXI.RVALID  = r_rvalid;
  assign S_AXI.RDATA   = r_rdata;
  assign S_AXI.RRESP   = r_rresp;

endmodule
